i2c_bus_arbiter: RTL and testbench
==================================

I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 24'd1_000_000, giving the maximum clk cycles to wait for each engine completion.
REQ-002 SHALL have port clk, input, 1 bit: system clock; all logic sits on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have ports req0_valid / req1_valid, input, 1 bit each: transaction request (0 = host path, 1 = sensor poller).
REQ-005 SHALL have ports reqN_slave, input, 7 bits; reqN_reg, input, 8 bits; reqN_rw, input, 1 bit (1 = read); reqN_len, input, 1 bit (0 = 1 byte, 1 = 2 bytes); reqN_wdata, input, 16 bits (MSB sent first).
REQ-006 SHALL have ports reqN_done, output, 1 bit (one-cycle pulse); reqN_err, output, 1 bit; reqN_rdata, output, 16 bits.
REQ-007 SHALL have engine ports eng_cmd, output, 2 bits (01 START+write, 10 write, 11 read); eng_last, output, 1 bit (STOP after this byte; for a read, NACK then STOP); eng_valid, output, 1 bit; eng_tx_byte, output, 8 bits.
REQ-008 SHALL have engine ports eng_ready, input, 1 bit; eng_done, input, 1 bit (pulse); eng_ack, input, 1 bit (sampled with eng_done); eng_rx_byte, input, 8 bits.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-010 States SHALL be IDLE, SLA_W, REG, WDATA, SLA_R, RDATA, FINISH.
REQ-011 Arbitration in IDLE SHALL be round-robin: with both requests valid, grant the requester not granted last; after reset, requester 0 has priority.
REQ-012 On grant, all request fields SHALL be latched; later changes to the inputs SHALL NOT affect the transaction in flight.
REQ-013 Grant SHALL occur in the cycle a valid request is seen in IDLE; the first eng_valid SHALL follow no earlier than the next cycle.
REQ-014 eng_valid SHALL be a one-cycle pulse, issued only while eng_ready=1, with eng_cmd, eng_last and eng_tx_byte stable in that cycle.
REQ-015 After eng_valid, the block SHALL NOT issue another command until eng_done.
REQ-016 The write sequence SHALL be: SLA_W (cmd 01, byte {slave,0}) -> REG (cmd 10) -> WDATA (cmd 10, 1 or 2 bytes, eng_last on the final byte) -> FINISH.
REQ-017 The read sequence SHALL be: SLA_W -> REG -> SLA_R (cmd 01, byte {slave,1}, repeated start) -> RDATA (cmd 11, 1 or 2 bytes, eng_last on the final byte) -> FINISH.
REQ-018 Read bytes SHALL assemble MSB-first into rdata.
REQ-019 For a 1-byte read, rdata SHALL be {8'h00, byte}.
REQ-020 eng_ack=0 on any SLA_W, REG, WDATA or SLA_R byte SHALL abort the transaction: issue no further bytes except one cmd 10 with eng_last=1 and byte 8'h00 to force STOP, then go to FINISH with err=1.
REQ-021 eng_ack on RDATA bytes SHALL be ignored.
REQ-022 The watchdog counter SHALL clear on every eng_valid and count while waiting for eng_done.
REQ-023 On reaching TIMEOUT_CYC, the block SHALL go to FINISH with err=1, send no STOP, and clear the counter.
REQ-024 FINISH SHALL, for exactly one cycle: pulse the granted requester's done, update its err and its rdata (rdata only on a successful read), record it as last grant, and return to IDLE.
REQ-025 reqN_err and reqN_rdata SHALL hold their values until that requester's next done.
REQ-026 A request still held valid during its own FINISH cycle SHALL be re-arbitrated in IDLE on the following cycle.
REQ-027 The ungranted requester's done SHALL stay 0 throughout the transaction.
REQ-028 An eng_done arriving while not awaiting one SHALL be ignored.

Reset
REQ-029 reset_n=0 SHALL asynchronously force: state IDLE; eng_valid=0; eng_cmd=00; eng_last=0; eng_tx_byte=0; busy=0; both done=0, err=0, rdata=16'h0000; last grant=1 (so requester 0 wins first); watchdog=0.
REQ-030 If reset asserts mid-transaction, no completion SHALL be reported, and after release the block SHALL start from IDLE.

Verification
REQ-031 req0 write, slave 7'h4B, reg 8'h03, len 1, wdata 16'h0080, all ACK -> engine sees {01,96}, {10,03}, {10,80,last} -> req0_done pulse, err=0.
REQ-032 req1 read, slave 7'h4B, reg 8'h00, len 1, rx bytes 8'h0C then 8'hA0 -> engine sees SLA_W, REG, {01,97}, two cmd 11 (last on second) -> req1_rdata=16'h0CA0, err=0.
REQ-033 Both requests valid out of reset -> req0 served first, then req1, then req0 again if still valid.
REQ-034 NACK on SLA_W -> one cmd 10 with last=1 issued -> reqN_err=1, done pulse, no REG byte issued.
REQ-035 eng_done withheld with TIMEOUT_CYC=16 -> err=1 and done exactly 16 cycles after eng_valid, state IDLE.
REQ-036 reset_n pulsed low during RDATA -> outputs return to reset values at once and no done pulse is seen.

Source files
------------

// File: rtl/i2c_bus_arbiter.sv
// Two-requester I2C transaction arbiter: round-robin grant, then the register-access
// byte sequence is driven into a single-byte I2C engine, with NACK abort and a watchdog.
module i2c_bus_arbiter #(
    parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    input  logic [6:0]  req0_slave,
    input  logic [7:0]  req0_reg,
    input  logic        req0_rw,
    input  logic        req0_len,
    input  logic [15:0] req0_wdata,
    output logic        req0_done,
    output logic        req0_err,
    output logic [15:0] req0_rdata,
    input  logic        req1_valid,
    input  logic [6:0]  req1_slave,
    input  logic [7:0]  req1_reg,
    input  logic        req1_rw,
    input  logic        req1_len,
    input  logic [15:0] req1_wdata,
    output logic        req1_done,
    output logic        req1_err,
    output logic [15:0] req1_rdata,
    output logic [1:0]  eng_cmd,
    output logic        eng_last,
    output logic        eng_valid,
    output logic [7:0]  eng_tx_byte,
    input  logic        eng_ready,
    input  logic        eng_done,
    input  logic        eng_ack,
    input  logic [7:0]  eng_rx_byte,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SLA_W  = 3'd1,
        ST_REG    = 3'd2,
        ST_WDATA  = 3'd3,
        ST_SLA_R  = 3'd4,
        ST_RDATA  = 3'd5,
        ST_FINISH = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic            gnt_q, gnt_d, last_gnt_q, last_gnt_d;
    logic [6:0]      slave_q, slave_d;
    logic [7:0]      reg_q, reg_d;
    logic            rw_q, rw_d, len_q, len_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [7:0]      rx_q, rx_d;
    logic            idx_q, idx_d, wait_q, wait_d, abort_q, abort_d;
    logic [23:0]     wdog_q, wdog_d;
    logic            eng_valid_q, eng_valid_d, eng_last_q, eng_last_d;
    logic [1:0]      eng_cmd_q, eng_cmd_d;
    logic [7:0]      eng_tx_q, eng_tx_d;
    logic            busy_q, busy_d;
    logic [1:0]      done_q, done_d, err_q, err_d;
    logic [1:0][15:0] rdata_q, rdata_d;

    logic [1:0]      cmd_s;
    logic [7:0]      byte_s;
    logic            last_s, pick_s, fin_go_s, fin_err_s;

    // Next-state, command generation and completion reporting
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_gnt_d  = last_gnt_q;
        slave_d     = slave_q;
        reg_d       = reg_q;
        rw_d        = rw_q;
        len_d       = len_q;
        wdata_d     = wdata_q;
        rx_d        = rx_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        abort_d     = abort_q;
        wdog_d      = wdog_q;
        eng_valid_d = 1'b0;
        eng_cmd_d   = eng_cmd_q;
        eng_last_d  = eng_last_q;
        eng_tx_d    = eng_tx_q;
        done_d      = 2'b00;
        err_d       = err_q;
        rdata_d     = rdata_q;
        fin_go_s    = 1'b0;
        fin_err_s   = 1'b0;
        pick_s      = (req0_valid && req1_valid) ? ~last_gnt_q : ~req0_valid;

        case (state_q)
            ST_SLA_W: begin cmd_s = 2'b01; byte_s = {slave_q, 1'b0}; last_s = 1'b0; end
            ST_REG:   begin cmd_s = 2'b10; byte_s = reg_q;           last_s = 1'b0; end
            ST_WDATA: begin
                cmd_s  = 2'b10;
                byte_s = (len_q && !idx_q) ? wdata_q[15:8] : wdata_q[7:0];
                last_s = !len_q || idx_q;
            end
            ST_SLA_R: begin cmd_s = 2'b01; byte_s = {slave_q, 1'b1}; last_s = 1'b0; end
            ST_RDATA: begin cmd_s = 2'b11; byte_s = 8'h00; last_s = !len_q || idx_q; end
            default:  begin cmd_s = 2'b00; byte_s = 8'h00; last_s = 1'b0; end
        endcase

        case (state_q)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    gnt_d   = pick_s;
                    slave_d = pick_s ? req1_slave : req0_slave;
                    reg_d   = pick_s ? req1_reg   : req0_reg;
                    rw_d    = pick_s ? req1_rw    : req0_rw;
                    len_d   = pick_s ? req1_len   : req0_len;
                    wdata_d = pick_s ? req1_wdata : req0_wdata;
                    rx_d    = 8'h00;
                    idx_d   = 1'b0;
                    wait_d  = 1'b0;
                    abort_d = 1'b0;
                    wdog_d  = 24'd0;
                    state_d = ST_SLA_W;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SLA_W, ST_REG, ST_WDATA, ST_SLA_R, ST_RDATA: begin
                if (!wait_q) begin
                    if (eng_ready) begin
                        // A pending abort replaces the scheduled byte with a bare STOP
                        eng_valid_d = 1'b1;
                        eng_cmd_d   = abort_q ? 2'b10 : cmd_s;
                        eng_tx_d    = abort_q ? 8'h00 : byte_s;
                        eng_last_d  = abort_q ? 1'b1  : last_s;
                        wait_d      = 1'b1;
                        wdog_d      = 24'd0;
                    end else begin
                        wait_d = 1'b0;
                    end
                end else if (eng_done) begin
                    wait_d = 1'b0;
                    wdog_d = 24'd0;
                    if (abort_q) begin
                        fin_go_s  = 1'b1;
                        fin_err_s = 1'b1;
                    end else if (!eng_ack && (state_q != ST_RDATA)) begin
                        abort_d = 1'b1;
                    end else begin
                        case (state_q)
                            ST_SLA_W: state_d = ST_REG;
                            ST_REG:   state_d = rw_q ? ST_SLA_R : ST_WDATA;
                            ST_WDATA: begin
                                if (last_s) fin_go_s = 1'b1;
                                else        idx_d    = 1'b1;
                            end
                            ST_SLA_R: state_d = ST_RDATA;
                            ST_RDATA: begin
                                rx_d = eng_rx_byte;
                                if (last_s) fin_go_s = 1'b1;
                                else        idx_d    = 1'b1;
                            end
                            default: begin
                                fin_go_s  = 1'b1;
                                fin_err_s = 1'b1;
                            end
                        endcase
                    end
                end else if ((wdog_q + 24'd1) == TIMEOUT_CYC) begin
                    fin_go_s  = 1'b1;
                    fin_err_s = 1'b1;
                end else begin
                    wdog_d = wdog_q + 24'd1;
                end
            end
            ST_FINISH: begin
                last_gnt_d = gnt_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Completion outputs are loaded on entry so they are visible during FINISH itself
        if (fin_go_s) begin
            state_d        = ST_FINISH;
            done_d[gnt_q]  = 1'b1;
            err_d[gnt_q]   = fin_err_s;
            wait_d         = 1'b0;
            abort_d        = 1'b0;
            wdog_d         = 24'd0;
            if (!fin_err_s && rw_q) begin
                rdata_d[gnt_q] = {rx_q, eng_rx_byte};
            end else begin
                rdata_d[gnt_q] = rdata_q[gnt_q];
            end
        end else begin
            done_d = 2'b00;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 1'b0;
            last_gnt_q  <= 1'b1;
            slave_q     <= 7'h00;
            reg_q       <= 8'h00;
            rw_q        <= 1'b0;
            len_q       <= 1'b0;
            wdata_q     <= 16'h0000;
            rx_q        <= 8'h00;
            idx_q       <= 1'b0;
            wait_q      <= 1'b0;
            abort_q     <= 1'b0;
            wdog_q      <= 24'd0;
            eng_valid_q <= 1'b0;
            eng_cmd_q   <= 2'b00;
            eng_last_q  <= 1'b0;
            eng_tx_q    <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 2'b00;
            err_q       <= 2'b00;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_gnt_q  <= last_gnt_d;
            slave_q     <= slave_d;
            reg_q       <= reg_d;
            rw_q        <= rw_d;
            len_q       <= len_d;
            wdata_q     <= wdata_d;
            rx_q        <= rx_d;
            idx_q       <= idx_d;
            wait_q      <= wait_d;
            abort_q     <= abort_d;
            wdog_q      <= wdog_d;
            eng_valid_q <= eng_valid_d;
            eng_cmd_q   <= eng_cmd_d;
            eng_last_q  <= eng_last_d;
            eng_tx_q    <= eng_tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

    assign eng_valid   = eng_valid_q;
    assign eng_cmd     = eng_cmd_q;
    assign eng_last    = eng_last_q;
    assign eng_tx_byte = eng_tx_q;
    assign busy        = busy_q;
    assign req0_done   = done_q[0];
    assign req1_done   = done_q[1];
    assign req0_err    = err_q[0];
    assign req1_err    = err_q[1];
    assign req0_rdata  = rdata_q[0];
    assign req1_rdata  = rdata_q[1];

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: a behavioural byte engine logs every command
// and answers with scripted ACK/NACK and read bytes; expectations are hand-computed.
module tb_i2c_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req0_rw, req0_len, req0_done, req0_err;
    logic [6:0]  req0_slave;
    logic [7:0]  req0_reg;
    logic [15:0] req0_wdata, req0_rdata;
    logic        req1_valid, req1_rw, req1_len, req1_done, req1_err;
    logic [6:0]  req1_slave;
    logic [7:0]  req1_reg;
    logic [15:0] req1_wdata, req1_rdata;
    logic [1:0]  eng_cmd;
    logic        eng_last, eng_valid, eng_ready, eng_done, eng_ack;
    logic [7:0]  eng_tx_byte, eng_rx_byte;
    logic        busy;

    always #5 clk = ~clk;

    i2c_bus_arbiter #(.TIMEOUT_CYC(24'd16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_slave(req0_slave), .req0_reg(req0_reg),
        .req0_rw(req0_rw), .req0_len(req0_len), .req0_wdata(req0_wdata),
        .req0_done(req0_done), .req0_err(req0_err), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_slave(req1_slave), .req1_reg(req1_reg),
        .req1_rw(req1_rw), .req1_len(req1_len), .req1_wdata(req1_wdata),
        .req1_done(req1_done), .req1_err(req1_err), .req1_rdata(req1_rdata),
        .eng_cmd(eng_cmd), .eng_last(eng_last), .eng_valid(eng_valid),
        .eng_tx_byte(eng_tx_byte), .eng_ready(eng_ready), .eng_done(eng_done),
        .eng_ack(eng_ack), .eng_rx_byte(eng_rx_byte), .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [10:0] log_e [0:127];
    int          log_c [0:127];
    int          log_n = 0;
    int          base = 0;
    int          nack_at = -1;
    bit          hold_done = 1'b0;
    int          stray_req = 0;
    logic [7:0]  rx_tab [0:7];
    int          rx_i = 0;
    int          d0 = 0, d1 = 0, dlong = 0;
    int          e0 = 0, e1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural engine: logs {cmd,last,byte}, answers two cycles later
    initial begin
        int stray_ack;
        int idx;
        logic [10:0] ent;
        stray_ack   = 0;
        eng_ready   = 1'b1;
        eng_done    = 1'b0;
        eng_ack     = 1'b1;
        eng_rx_byte = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (stray_req != stray_ack) begin
                eng_done = 1'b1;
                @(posedge clk); #1;
                eng_done = 1'b0;
                stray_ack++;
            end else if (eng_valid) begin
                ent = {eng_cmd, eng_last, eng_tx_byte};
                log_e[log_n & 127] = ent;
                log_c[log_n & 127] = cyc;
                idx = log_n - base;
                log_n++;
                if (!hold_done) begin
                    repeat (2) @(posedge clk);
                    #1;
                    eng_done = 1'b1;
                    eng_ack  = (idx == nack_at) ? 1'b0 : 1'b1;
                    if (ent[10:9] == 2'b11) begin
                        eng_rx_byte = rx_tab[rx_i & 7];
                        rx_i++;
                    end else begin
                        eng_rx_byte = 8'hEE;
                    end
                    @(posedge clk); #1;
                    eng_done = 1'b0;
                    eng_ack  = 1'b1;
                end
            end
        end
    end

    // Done-pulse monitor
    initial begin
        bit p0, p1;
        p0 = 1'b0;
        p1 = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (req0_done) d0++;
            if (req1_done) d1++;
            if ((req0_done && p0) || (req1_done && p1)) dlong++;
            p0 = req0_done;
            p1 = req1_done;
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic start_req(input bit r, input logic [6:0] sl, input logic [7:0] rg,
                             input logic rw, input logic ln, input logic [15:0] wd);
        bit ok;
        base = log_n;
        if (!r) begin
            req0_slave = sl; req0_reg = rg; req0_rw = rw; req0_len = ln; req0_wdata = wd;
            req0_valid = 1'b1;
        end else begin
            req1_slave = sl; req1_reg = rg; req1_rw = rw; req1_len = ln; req1_wdata = wd;
            req1_valid = 1'b1;
        end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (busy) begin ok = 1'b1; break; end
        end
        check_eq("grant", {31'd0, ok}, 32'd1);
        // Scramble inputs: the transaction in flight must use latched values
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_slave = 7'h7F; req1_slave = 7'h7F; req0_reg = 8'hFF; req1_reg = 8'hFF;
        req0_rw = ~rw; req1_rw = ~rw; req0_len = ~ln; req1_len = ~ln;
        req0_wdata = 16'h5555; req1_wdata = 16'h5555;
    endtask

    task automatic wait_done(input bit r, output bit ok, output int dc);
        ok = 1'b0;
        dc = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if ((!r && req0_done) || (r && req1_done)) begin ok = 1'b1; dc = cyc; break; end
        end
    endtask

    task automatic wait_any(output int which);
        which = -1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (req0_done) begin which = 0; break; end
            if (req1_done) begin which = 1; break; end
        end
    endtask

    task automatic check_log(input string tag, input int k, input logic [10:0] exp, input bit cmd_only);
        if (cmd_only) check_eq(tag, {29'd0, log_e[(base + k) & 127][10:8]}, {29'd0, exp[10:8]});
        else          check_eq(tag, {21'd0, log_e[(base + k) & 127]}, {21'd0, exp});
    endtask

    task automatic check_counts(input string tag);
        repeat (2) @(posedge clk);
        #1;
        check_eq(tag, {d0[15:0], d1[15:0]}, {e0[15:0], e1[15:0]});
    endtask

    initial begin
        bit ok;
        int dc, w, v;
        rx_tab[0] = 8'h0C; rx_tab[1] = 8'hA0; rx_tab[2] = 8'h5A; rx_tab[3] = 8'h11;
        rx_tab[4] = 8'h22; rx_tab[5] = 8'h33; rx_tab[6] = 8'h44; rx_tab[7] = 8'h55;
        req0_valid = 1'b0; req0_slave = 7'h00; req0_reg = 8'h00; req0_rw = 1'b0;
        req0_len = 1'b0; req0_wdata = 16'h0000;
        req1_valid = 1'b0; req1_slave = 7'h00; req1_reg = 8'h00; req1_rw = 1'b0;
        req1_len = 1'b0; req1_wdata = 16'h0000;
        do_reset();

        check_eq("rst_outs", {busy, eng_valid, eng_cmd, eng_last, eng_tx_byte,
                              req0_done, req1_done, req0_err, req1_err}, 32'd0);
        check_eq("rst_rdata", {req0_rdata, req1_rdata}, 32'd0);

        // Single-byte write from requester 0
        start_req(1'b0, 7'h4B, 8'h03, 1'b0, 1'b0, 16'h0080);
        wait_done(1'b0, ok, dc);
        e0++;
        check_eq("wr1_done", {31'd0, ok}, 32'd1);
        check_eq("wr1_n", log_n - base, 3);
        check_log("wr1_b0", 0, {2'b01, 1'b0, 8'h96}, 1'b0);
        check_log("wr1_b1", 1, {2'b10, 1'b0, 8'h03}, 1'b0);
        check_log("wr1_b2", 2, {2'b10, 1'b1, 8'h80}, 1'b0);
        check_eq("wr1_err", {31'd0, req0_err}, 32'd0);
        check_counts("wr1_cnt");

        // Two-byte read from requester 1
        start_req(1'b1, 7'h4B, 8'h00, 1'b1, 1'b1, 16'h0000);
        wait_done(1'b1, ok, dc);
        e1++;
        check_eq("rd2_done", {31'd0, ok}, 32'd1);
        check_eq("rd2_n", log_n - base, 5);
        check_log("rd2_b0", 0, {2'b01, 1'b0, 8'h96}, 1'b0);
        check_log("rd2_b1", 1, {2'b10, 1'b0, 8'h00}, 1'b0);
        check_log("rd2_b2", 2, {2'b01, 1'b0, 8'h97}, 1'b0);
        check_log("rd2_b3", 3, {2'b11, 1'b0, 8'h00}, 1'b1);
        check_log("rd2_b4", 4, {2'b11, 1'b1, 8'h00}, 1'b1);
        check_eq("rd2_rdata", {16'd0, req1_rdata}, 32'h0CA0);
        check_eq("rd2_err", {31'd0, req1_err}, 32'd0);
        check_counts("rd2_cnt");

        // Round-robin with both requests held valid from reset
        do_reset();
        d0 = 0; d1 = 0; e0 = 0; e1 = 0;
        req0_slave = 7'h11; req0_reg = 8'h01; req0_rw = 1'b0; req0_len = 1'b0; req0_wdata = 16'h0001;
        req1_slave = 7'h22; req1_reg = 8'h02; req1_rw = 1'b0; req1_len = 1'b0; req1_wdata = 16'h0002;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_any(w);
        check_eq("arb_first", w, 0);
        wait_any(w);
        check_eq("arb_second", w, 1);
        wait_any(w);
        check_eq("arb_third", w, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        e0 = 2; e1 = 1;
        check_counts("arb_cnt");

        // Two-byte write, MSB first
        start_req(1'b0, 7'h10, 8'h22, 1'b0, 1'b1, 16'hBEEF);
        wait_done(1'b0, ok, dc);
        e0++;
        check_eq("wr2_n", log_n - base, 4);
        check_log("wr2_b0", 0, {2'b01, 1'b0, 8'h20}, 1'b0);
        check_log("wr2_b1", 1, {2'b10, 1'b0, 8'h22}, 1'b0);
        check_log("wr2_b2", 2, {2'b10, 1'b0, 8'hBE}, 1'b0);
        check_log("wr2_b3", 3, {2'b10, 1'b1, 8'hEF}, 1'b0);

        // Single-byte read pads the high byte with zero
        start_req(1'b0, 7'h50, 8'h01, 1'b1, 1'b0, 16'h0000);
        wait_done(1'b0, ok, dc);
        e0++;
        check_eq("rd1_n", log_n - base, 4);
        check_log("rd1_b2", 2, {2'b01, 1'b0, 8'hA1}, 1'b0);
        check_log("rd1_b3", 3, {2'b11, 1'b1, 8'h00}, 1'b1);
        check_eq("rd1_rdata", {16'd0, req0_rdata}, 32'h005A);
        check_counts("rd1_cnt");

        // NACK on the address byte forces a bare STOP and an error
        nack_at = 0;
        start_req(1'b1, 7'h33, 8'h44, 1'b0, 1'b0, 16'h0077);
        wait_done(1'b1, ok, dc);
        e1++;
        nack_at = -1;
        check_eq("nack_done", {31'd0, ok}, 32'd1);
        check_eq("nack_n", log_n - base, 2);
        check_log("nack_b0", 0, {2'b01, 1'b0, 8'h66}, 1'b0);
        check_log("nack_stop", 1, {2'b10, 1'b1, 8'h00}, 1'b0);
        check_eq("nack_err", {31'd0, req1_err}, 32'd1);
        check_counts("nack_cnt");

        // Watchdog expiry with the engine silent
        hold_done = 1'b1;
        start_req(1'b0, 7'h4B, 8'h03, 1'b0, 1'b0, 16'h0080);
        wait_done(1'b0, ok, dc);
        e0++;
        check_eq("to_done", {31'd0, ok}, 32'd1);
        check_eq("to_lat", dc - log_c[base & 127], 16);
        check_eq("to_err", {31'd0, req0_err}, 32'd1);
        check_eq("to_rdata_hold", {16'd0, req0_rdata}, 32'h005A);
        check_eq("to_n", log_n - base, 1);
        @(posedge clk); #1;
        check_eq("to_idle", {31'd0, busy}, 32'd0);
        hold_done = 1'b0;

        // Stray eng_done while idle is ignored
        stray_req++;
        repeat (4) @(posedge clk);
        #1;
        check_eq("stray_busy", {31'd0, busy}, 32'd0);
        check_counts("stray_cnt");

        // Reset asserted during RDATA
        start_req(1'b1, 7'h4B, 8'h00, 1'b1, 1'b1, 16'h0000);
        v = 0;
        for (int i = 0; i < 200; i++) begin
            if ((log_n - base) >= 4) begin v = 1; break; end
            @(posedge clk); #1;
        end
        check_eq("rst_mid_reach", v, 1);
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_outs", {busy, eng_valid, eng_cmd, eng_last, eng_tx_byte,
                                  req0_done, req1_done, req0_err, req1_err}, 32'd0);
        check_eq("rst_mid_rdata", {req0_rdata, req1_rdata}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_eq("rst_mid_idle", {31'd0, busy}, 32'd0);
        check_counts("rst_mid_cnt");
        check_eq("done_width", dlong, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
